// File: rtl/icg_pkg.sv
// ---------------------------------------------------------------------------
// icg_pkg
// Shared definitions for the idle-driven clock-gating controller.
//   icg_state_e  : per-domain FSM state (ON / WAKE / GATED)
//   *_DEF        : default values for the top-level parameters
//   WAKE_CNT_W   : width of the per-domain wake-settle counter
// ---------------------------------------------------------------------------
package icg_pkg;

  typedef enum logic [1:0] {
    ST_ON    = 2'b00,
    ST_WAKE  = 2'b01,
    ST_GATED = 2'b10
  } icg_state_e;

  localparam int NUM_DOM_DEF  = 2;
  localparam int IDLE_W_DEF   = 8;
  localparam int WAKE_CYC_DEF = 2;
  localparam int WAKE_CNT_W   = 4;

endpackage : icg_pkg

// File: rtl/icg_dom_fsm.sv
// ---------------------------------------------------------------------------
// icg_dom_fsm
// One gated domain: idle counter, wake-settle counter and ON/WAKE/GATED FSM.
// Ports:
//   clk, rst_n  : system clock, asynchronous active-low reset
//   busy        : act | wake_req | force_on for this domain
//   idle_thr    : idle cycles before gating (0 = never gate)
//   gate_en     : registered ICG enable (low only in GATED)
//   ready       : registered, domain running and settled (ON only)
//   gated       : registered, domain clock stopped (GATED only)
//   state_nxt   : next FSM state; debug visibility and all_gated source
// ---------------------------------------------------------------------------
module icg_dom_fsm
  import icg_pkg::*;
#(
  parameter int IDLE_W   = IDLE_W_DEF,
  parameter int WAKE_CYC = WAKE_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              busy,
  input  logic [IDLE_W-1:0] idle_thr,
  output logic              gate_en,
  output logic              ready,
  output logic              gated,
  output icg_state_e        state_nxt
);

  icg_state_e            state_q, state_d;
  logic [IDLE_W-1:0]     idle_cnt_q, idle_cnt_d;
  logic [WAKE_CNT_W-1:0] wake_cnt_q, wake_cnt_d;
  logic                  gate_en_q, gate_en_d;
  logic                  ready_q, ready_d;
  logic                  gated_q, gated_d;
  logic [IDLE_W-1:0]     thr_m1;

  // Only used when idle_thr != 0, so the wrap at zero is never observed.
  assign thr_m1 = idle_thr - IDLE_W'(1);

  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    wake_cnt_d = wake_cnt_q;
    unique case (state_q)
      ST_ON: begin
        // Busy has priority over a threshold hit on the same cycle.
        if (busy || (idle_thr == '0)) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q >= thr_m1) begin
          state_d    = ST_GATED;
          idle_cnt_d = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + IDLE_W'(1);
        end
      end
      ST_GATED: begin
        if (busy) begin
          state_d    = ST_WAKE;
          wake_cnt_d = '0;
        end
      end
      ST_WAKE: begin
        // Input activity is ignored here; a wake always runs to completion.
        wake_cnt_d = wake_cnt_q + WAKE_CNT_W'(1);
        if (wake_cnt_q == WAKE_CNT_W'(WAKE_CYC - 1)) begin
          state_d    = ST_ON;
          wake_cnt_d = '0;
        end
      end
      default: begin
        state_d    = ST_ON;
        idle_cnt_d = '0;
        wake_cnt_d = '0;
      end
    endcase

    // Outputs are decoded from the next state and registered, so gate_en
    // only moves on the rising edge while the ICG latch is opaque.
    gate_en_d = (state_d != ST_GATED);
    ready_d   = (state_d == ST_ON);
    gated_d   = (state_d == ST_GATED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_ON;
      idle_cnt_q <= '0;
      wake_cnt_q <= '0;
      gate_en_q  <= 1'b1;
      ready_q    <= 1'b1;
      gated_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      wake_cnt_q <= wake_cnt_d;
      gate_en_q  <= gate_en_d;
      ready_q    <= ready_d;
      gated_q    <= gated_d;
    end
  end

  assign gate_en   = gate_en_q;
  assign ready     = ready_q;
  assign gated     = gated_q;
  assign state_nxt = state_d;

endmodule : icg_dom_fsm

// File: rtl/icg_ctrl.sv
// ---------------------------------------------------------------------------
// icg_ctrl
// Idle-driven clock-gating controller for NUM_DOM independent domains.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   act        : per-domain activity (level)
//   wake_req   : per-domain wake request (level)
//   force_on   : per-domain software override, keeps domain ungated
//   idle_thr   : shared idle threshold in cycles, 0 disables gating
//   gate_en    : per-domain ICG enable (registered)
//   ready      : per-domain running-and-settled (registered)
//   gated      : per-domain clock stopped (registered)
//   all_gated  : every domain gated (registered)
// ---------------------------------------------------------------------------
module icg_ctrl
  import icg_pkg::*;
#(
  parameter int NUM_DOM  = NUM_DOM_DEF,
  parameter int IDLE_W   = IDLE_W_DEF,
  parameter int WAKE_CYC = WAKE_CYC_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_DOM-1:0] act,
  input  logic [NUM_DOM-1:0] wake_req,
  input  logic [NUM_DOM-1:0] force_on,
  input  logic [IDLE_W-1:0]  idle_thr,
  output logic [NUM_DOM-1:0] gate_en,
  output logic [NUM_DOM-1:0] ready,
  output logic [NUM_DOM-1:0] gated,
  output logic               all_gated
);

  logic [NUM_DOM-1:0] busy;
  logic [NUM_DOM-1:0] gated_nxt;
  icg_state_e         state_nxt [NUM_DOM];
  logic               all_gated_q, all_gated_d;

  assign busy = act | wake_req | force_on;

  for (genvar g = 0; g < NUM_DOM; g++) begin : g_dom
    icg_dom_fsm #(
      .IDLE_W   (IDLE_W),
      .WAKE_CYC (WAKE_CYC)
    ) u_dom (
      .clk       (clk),
      .rst_n     (rst_n),
      .busy      (busy[g]),
      .idle_thr  (idle_thr),
      .gate_en   (gate_en[g]),
      .ready     (ready[g]),
      .gated     (gated[g]),
      .state_nxt (state_nxt[g])
    );
    assign gated_nxt[g] = (state_nxt[g] == ST_GATED);
  end

  // Built from the domains' next states so it updates on the same edge
  // as the per-domain gated flops.
  always_comb begin
    all_gated_d = &gated_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      all_gated_q <= 1'b0;
    end else begin
      all_gated_q <= all_gated_d;
    end
  end

  assign all_gated = all_gated_q;

endmodule : icg_ctrl
